// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Owns the PC, issues one word read per cycle to
// memory, buffers returned words (with their PC) in a DEPTH-entry FIFO and
// hands them to decode over a valid/ready handshake. A redirect from execute
// reloads the PC and flushes everything buffered or in flight.
//
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous active-low reset
//   mem_req_valid     read request issued this cycle
//   mem_read_address  word address of the request (current PC)
//   mem_read_data     read data, valid one cycle after the request
//   redirect_valid    load redirect_target into the PC and flush
//   redirect_target   new PC
//   instr_valid       head instruction available
//   instr_ready       decode accepts the head instruction
//   instr             head instruction word
//   instr_pc          PC of the head instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = PW + 1;      // count holds 0..DEPTH
    localparam int OCW = CW + 1;      // occupancy sum before subtracting pop

    logic [31:0]   r_pc;
    logic          r_inflight;
    logic [31:0]   r_inflight_pc;
    logic          r_squash;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_buf_instr [DEPTH];
    logic [31:0]   r_buf_pc    [DEPTH];
    logic [31:0]   r_hold_instr;
    logic [31:0]   r_hold_pc;

    logic           w_nonempty;
    logic           w_pop;
    logic           w_push;
    logic           w_issue;
    logic [OCW-1:0] w_occ;

    assign w_nonempty  = (r_count != '0);
    assign instr_valid = w_nonempty && !redirect_valid;
    assign w_pop       = instr_valid && instr_ready;

    // Slots committed after this edge: buffered + the word now returning,
    // minus the one leaving. Issuing only below DEPTH means the reply to this
    // request always finds room, so a push never has to be refused.
    assign w_occ   = OCW'(r_count) + OCW'(r_inflight) - OCW'(w_pop);
    assign w_issue = rst && !redirect_valid && (w_occ < OCW'(DEPTH));

    // A reply landing in a redirect cycle belongs to the old stream.
    assign w_push = r_inflight && !r_squash && !redirect_valid;

    assign mem_req_valid    = w_issue;
    assign mem_read_address = r_pc;

    // Head is shown while anything is buffered; otherwise the last head seen.
    assign instr    = w_nonempty ? r_buf_instr[r_rd_ptr] : r_hold_instr;
    assign instr_pc = w_nonempty ? r_buf_pc[r_rd_ptr]    : r_hold_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
            r_squash      <= 1'b0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_hold_instr  <= 32'h0;
            r_hold_pc     <= 32'h0;
        end else begin
            if (w_nonempty) begin
                r_hold_instr <= r_buf_instr[r_rd_ptr];
                r_hold_pc    <= r_buf_pc[r_rd_ptr];
            end

            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc          <= r_pc + 32'd1;   // wraps FFFFFFFF -> 0
                r_inflight_pc <= r_pc;
            end

            if (redirect_valid) begin
                r_pc     <= redirect_target;
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                // Marks a request issued alongside a redirect as stale. Issue
                // is blocked in redirect cycles, so this stays clear today.
                r_squash <= w_issue;
            end else begin
                r_squash <= 1'b0;
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Payload storage needs no reset: it is only visible while count != 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_instr[r_wr_ptr] <= mem_read_data;
            r_buf_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory responder returning address+100, a queue
// model of the buffered stream checked every cycle, and directed scenarios
// with hand-computed expectations.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic [31:0] mem_read_address;
    logic [31:0] mem_read_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_req_valid    (mem_req_valid),
        .mem_read_address (mem_read_address),
        .mem_read_data    (mem_read_data),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .instr_pc         (instr_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: data for the address requested in the previous cycle.
    always @(posedge clk) begin
        if (mem_req_valid) mem_read_data <= mem_read_address + 32'd100;
        else               mem_read_data <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_buf[$];     // words held by the fetch buffer
    ent_t        log_q[$];     // words handed to decode
    logic        m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_next_pc;
    logic [31:0] m_last_i;
    logic [31:0] m_last_p;

    always @(negedge clk) begin
        logic exp_vld;
        logic exp_pop;
        logic exp_iss;
        int   occ;
        if (!rst) begin
            m_buf.delete();
            m_infl    = 1'b0;
            m_infl_pc = 32'h0;
            m_next_pc = RESET_PC;
            m_last_i  = 32'h0;
            m_last_p  = 32'h0;
            chk("m_rst_req", {31'h0, mem_req_valid}, 32'h0);
            chk("m_rst_vld", {31'h0, instr_valid}, 32'h0);
        end else begin
            exp_vld = (m_buf.size() != 0) && !redirect_valid;
            exp_pop = exp_vld && instr_ready;
            occ     = m_buf.size() + int'(m_infl) - int'(exp_pop);
            exp_iss = !redirect_valid && (occ < DEPTH);
            chk("m_vld", {31'h0, instr_valid}, {31'h0, exp_vld});
            chk("m_req", {31'h0, mem_req_valid}, {31'h0, exp_iss});
            if (exp_iss) chk("m_addr", mem_read_address, m_next_pc);
            if (m_buf.size() != 0) begin
                chk("m_instr", instr, m_buf[0].ins);
                chk("m_pc", instr_pc, m_buf[0].pc);
                m_last_i = m_buf[0].ins;
                m_last_p = m_buf[0].pc;
            end else begin
                chk("m_hold_instr", instr, m_last_i);
                chk("m_hold_pc", instr_pc, m_last_p);
            end
            // advance to the state after the coming edge
            if (redirect_valid) begin
                m_buf.delete();
                m_infl    = 1'b0;
                m_next_pc = redirect_target;
            end else begin
                if (exp_pop) begin
                    log_q.push_back(m_buf[0]);
                    void'(m_buf.pop_front());
                end
                if (m_infl) m_buf.push_back({m_infl_pc + 32'd100, m_infl_pc});
                m_infl    = exp_iss;
                m_infl_pc = m_next_pc;
                if (exp_iss) m_next_pc = m_next_pc + 32'd1;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = rdy;
        step(2);
        rst = 1'b1;
        log_q.delete();
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [31:0] pc);
        if (log_q.size() <= idx) begin
            checks++;
            failures++;
            $display("FAIL %s actual=missing(log size %0d) expected=pc %h", nm, log_q.size(), pc);
        end else begin
            chk({nm, "_pc"}, log_q[idx].pc, pc);
            chk({nm, "_instr"}, log_q[idx].ins, pc + 32'd100);
        end
    endtask

    task automatic wait_req(input logic [31:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (mem_req_valid && mem_read_address == a) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL wait_req actual=timeout expected=request %h", a);
        end
        step(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw5;
        rst             = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        instr_ready     = 1'b1;
        step(2);
        chk("rst_req",   {31'h0, mem_req_valid}, 32'h0);
        chk("rst_vld",   {31'h0, instr_valid},   32'h0);
        chk("rst_instr", instr,    32'h0);
        chk("rst_pc",    instr_pc, 32'h0);

        // Startup: requests 0,1,2 back to back; first valid two cycles later
        rst = 1'b1;
        log_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("su_req",  {31'h0, mem_req_valid}, 32'h1);
            chk("su_addr", mem_read_address, i);
            chk("su_vld",  {31'h0, instr_valid}, (i == 2) ? 32'h1 : 32'h0);
            step(1);
        end
        step(3);
        chk_log("su0", 0, 32'd0);
        chk_log("su1", 1, 32'd1);
        chk_log("su2", 2, 32'd2);

        // Backpressure: two entries held, no requests, head 100/0
        do_reset(1'b0);
        step(5);
        @(negedge clk);
        chk("bp_vld",   {31'h0, instr_valid},   32'h1);
        chk("bp_req",   {31'h0, mem_req_valid}, 32'h0);
        chk("bp_instr", instr,    32'd100);
        chk("bp_pc",    instr_pc, 32'd0);
        step(1);
        instr_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_req",  {31'h0, mem_req_valid}, 32'h1);
        chk("bp_resume_addr", mem_read_address, 32'd2);
        step(6);
        chk_log("bp0", 0, 32'd0);
        chk_log("bp1", 1, 32'd1);
        chk_log("bp2", 2, 32'd2);
        chk_log("bp3", 3, 32'd3);

        // Redirect the cycle after the request for PC 5
        do_reset(1'b1);
        wait_req(32'd5);
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        log_q.delete();
        @(negedge clk);
        chk("rd_vld", {31'h0, instr_valid}, 32'h0);
        step(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rd_req",  {31'h0, mem_req_valid}, 32'h1);
        chk("rd_addr", mem_read_address, 32'h40);
        step(6);
        chk_log("rd0", 0, 32'h40);
        chk_log("rd1", 1, 32'h41);
        saw5 = 1'b0;
        foreach (log_q[i]) if (log_q[i].pc == 32'd5) saw5 = 1'b1;
        chk("rd_no_pc5", {31'h0, saw5}, 32'h0);

        // Redirect with the buffer full and ready low
        do_reset(1'b0);
        step(5);
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        log_q.delete();
        @(negedge clk);
        chk("rf_vld0", {31'h0, instr_valid}, 32'h0);
        step(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rf_vld1", {31'h0, instr_valid}, 32'h0);
        chk("rf_addr", mem_read_address, 32'h80);
        step(1);
        @(negedge clk);
        chk("rf_vld2", {31'h0, instr_valid}, 32'h0);
        step(1);
        @(negedge clk);
        chk("rf_vld3",   {31'h0, instr_valid}, 32'h1);
        chk("rf_pc",     instr_pc, 32'h80);
        chk("rf_instr",  instr,    32'hE4);
        step(1);
        instr_ready = 1'b1;
        step(4);
        chk_log("rf0", 0, 32'h80);
        chk_log("rf1", 1, 32'h81);

        // PC wrap
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        log_q.delete();
        step(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wr_addr0", mem_read_address, 32'hFFFF_FFFF);
        step(1);
        @(negedge clk);
        chk("wr_addr1", mem_read_address, 32'h0);
        step(5);
        chk_log("wr0", 0, 32'hFFFF_FFFF);
        chk_log("wr1", 1, 32'h0);
        chk("wr_instr_lit", log_q.size() > 0 ? log_q[0].ins : 32'hX, 32'd99);

        // Reset mid-stream with two entries buffered
        do_reset(1'b0);
        step(5);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_vld",   {31'h0, instr_valid},   32'h0);
        chk("mr_req",   {31'h0, mem_req_valid}, 32'h0);
        chk("mr_instr", instr,    32'h0);
        chk("mr_pc",    instr_pc, 32'h0);
        step(1);
        rst         = 1'b1;
        instr_ready = 1'b1;
        log_q.delete();
        step(6);
        chk_log("mr0", 0, RESET_PC);
        chk_log("mr1", 1, RESET_PC + 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Owns the program counter and issues word reads to main memory.
- Buffers returned words in a small FIFO and presents them, tagged with their PC, to the downstream decode stage over a valid/ready handshake.
- Accepts a redirect (branch/jump target) from the execute stage. A redirect flushes buffered and in-flight fetches.
- Sits between the PC/ALU increment path and decode.

Parameters:
- RESET_PC, 32'h0, PC value loaded on reset.
- DEPTH, 2, fetch buffer entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- mem_req_valid  output  1  read request issued this cycle.
- mem_read_address  output  32  word address of the request; equals the current PC.
- mem_read_data  input  32  read data; valid exactly one cycle after the request cycle.
- redirect_valid  input  1  load a new PC and flush.
- redirect_target  input  32  new PC when redirect_valid is high.
- instr_valid  output  1  head instruction available.
- instr_ready  input  1  downstream accepts the head instruction.
- instr  output  32  head instruction word.
- instr_pc  output  32  PC of the head instruction.

Behaviour:
- State:
  - pc (32b).
  - FIFO of {instr, pc} entries, DEPTH deep, with count.
  - inflight (1b): a request was issued last cycle.
  - inflight_pc (32b).
  - squash (1b).
- Reset (rst low, asynchronous):
  - pc=RESET_PC, count=0, inflight=0, squash=0.
  - Outputs held: mem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
  - Reset asserted mid-operation drops all buffered and in-flight words, with no partial push afterwards.
- pop = instr_valid && instr_ready.
- Issue condition: rst high && !redirect_valid && (count + inflight - pop) < DEPTH.
- On issue:
  - mem_req_valid=1, mem_read_address=pc.
  - Next-cycle state: pc <= pc+1 (word addressing), inflight <= 1, inflight_pc <= pc.
  - pc wraps modulo 2^32: 32'hFFFFFFFF -> 32'h0.
- When not issuing: mem_req_valid=0, inflight <= 0, pc unchanged.
- Response:
  - In any cycle with inflight=1 and squash=0, {mem_read_data, inflight_pc} is pushed at the rising edge.
  - A push is never refused: the issue condition guarantees space.
- Output:
  - instr_valid = (count != 0) && !redirect_valid.
  - instr and instr_pc show the FIFO head whenever count != 0. Otherwise both hold their last value, or 0 after reset.
- Push and pop in the same cycle: count unchanged, order preserved.
- Redirect (redirect_valid=1):
  - This cycle: no issue, no pop, no push.
  - At the edge: count <= 0, pc <= redirect_target.
  - squash <= inflight_next (= 0, since no issue this cycle).
  - A response arriving in the redirect cycle itself is discarded.
  - Next cycle: the request for redirect_target is issued. The first redirected instruction is valid 2 cycles after that issue.
- Back-to-back redirects: the last one wins; each flushes.
- Latency: request in cycle t, data at mem_read_data in cycle t+1, instr_valid in cycle t+2.
- Throughput: with instr_ready held high, one instruction per cycle in steady state for DEPTH=2.
- Backpressure: with instr_ready low, issue stops once count+inflight reaches DEPTH. No instruction is lost or duplicated.
- Ordering: strictly ascending PC between redirects.

Test Plan:
- Startup:
  - Stimulus: release rst, memory returns addr+100, instr_ready=1.
  - Response: mem_read_address 0,1,2,... on consecutive cycles; instr_valid first high 2 cycles after first request; instr/instr_pc = 100/0, 101/1, 102/2 one per cycle.
- Backpressure:
  - Stimulus: instr_ready=0 from cycle 3, DEPTH=2.
  - Response: exactly 2 entries buffered, mem_req_valid low, head stays 100/0; releasing ready resumes with PC 2 next, no gaps or duplicates.
- Redirect with in-flight:
  - Stimulus: redirect_valid=1, target 32'h40, in the cycle after a request for PC 5.
  - Response: word for 5 never appears; instr_valid low in the redirect cycle; next request address 32'h40; next instruction delivered has instr_pc 32'h40.
- Redirect while buffer full:
  - Stimulus: redirect with ready=0 and 2 entries held.
  - Response: both entries dropped; instr_valid low until target word arrives.
- PC wrap:
  - Stimulus: redirect to 32'hFFFFFFFF.
  - Response: requests FFFFFFFF then 00000000; instr_pc sequence matches.
- Reset mid-stream:
  - Stimulus: assert rst low asynchronously between edges with 2 entries buffered.
  - Response: instr_valid and mem_req_valid drop immediately; after release, fetch restarts at RESET_PC with no stale words.
